// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings for the byte-serial data-memory sequencer: access sizes,
// FSM states, byte-count and alignment helpers.
package mem_access_sequencer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // The reserved size code behaves as a word wherever it is sequenced.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of a right-aligned 1/2/4-byte load value to 32 bits.
// Shared with the CPU writeback path.
module mem_load_extend
  import mem_access_sequencer_pkg::*;
(
  input  logic [31:0] raw_data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (size)
      SIZE_BYTE: ext_data = {{24{~is_unsigned & raw_data[7]}}, raw_data[7:0]};
      SIZE_HALF: ext_data = {{16{~is_unsigned & raw_data[15]}}, raw_data[15:0]};
      default:   ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Turns one CPU load/store into 1/2/4 single-byte memory accesses.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned requests complete at once with err).
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter bit BIG_END = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_wordaddr,
  output logic [7:0]        mem_writeData,
  output logic              mem_writeEnable,
  input  logic [7:0]        mem_readData
);
  import mem_access_sequencer_pkg::*;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       gather_q, gather_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_sel;
  logic [31:0]       wdata_shift;
  logic [31:0]       ext_data;
  logic              in_access;

  // Byte i of the access maps to byte slot (N-1-i) when the first address holds the MSB.
  assign byte_sel    = BIG_END ? (last_q - idx_q) : idx_q;
  assign wdata_shift = wdata_q >> {byte_sel, 3'b000};
  assign in_access   = (state_q == ST_ACCESS);

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign rdata           = rdata_q;
  assign mem_wordaddr    = addr_q;
  assign mem_writeEnable = in_access & we_q;
  assign mem_writeData   = (in_access & we_q) ? wdata_shift[7:0] : 8'h00;

  always_comb begin
    gather_d = gather_q;
    if (in_access && !we_q) begin
      gather_d[{byte_sel, 3'b000} +: 8] = mem_readData;
    end
  end

  mem_load_extend u_load_extend (
    .raw_data    (gather_d),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext_data    (ext_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign err = done & err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
`ifdef MEM_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          last_d  = 2'(byte_count(req_size) - 3'd1);
          idx_d   = 2'd0;
`ifdef MEM_ALIGN_CHECK_EN
          err_d = is_misaligned(req_size, req_addr[1:0]);
          // Misaligned requests skip memory entirely; the address bus is left untouched.
          if (err_d) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = req_addr;
            state_d = ST_ACCESS;
          end
`else
          addr_d  = req_addr;
          state_d = ST_ACCESS;
`endif
        end
      end
      ST_ACCESS: begin
        if (idx_q == last_q) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = ext_data;
          end
        end else begin
          idx_d  = idx_q + 2'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      last_q   <= 2'd0;
      we_q     <= 1'b0;
      size_q   <= SIZE_BYTE;
      uns_q    <= 1'b0;
      wdata_q  <= 32'h0;
      gather_q <= 32'h0;
      rdata_q  <= 32'h0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      // Each new request starts gathering from a clean slate.
      gather_q <= (state_q == ST_IDLE) ? 32'h0 : gather_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer against a 256-byte memory model, BIG_END=1.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the alignment-error path.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_wordaddr;
  logic [7:0]  mem_writeData;
  logic        mem_writeEnable;
  logic [7:0]  mem_readData;

  logic [7:0]  mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [7:0]  pl_data;

  int n_checks;
  int n_fail;

  mem_access_sequencer #(.ADDR_W(32), .BIG_END(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .busy            (busy),
    .done            (done),
    .rdata           (rdata),
    .err             (err),
    .mem_wordaddr    (mem_wordaddr),
    .mem_writeData   (mem_writeData),
    .mem_writeEnable (mem_writeEnable),
    .mem_readData    (mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_readData = mem[mem_wordaddr[7:0]];

  // Memory model: DUT writes, plus a bench preload port used only while the DUT is idle.
  always @(posedge clk) begin
    if (mem_writeEnable) mem[mem_wordaddr[7:0]] <= mem_writeData;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Issues one request, waits (bounded) for done, captures done-cycle values, returns to IDLE.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int cycles, output logic [31:0] rd, output logic er);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req          = 1'b1;
    tick();
    req    = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    rd = rdata;
    er = err;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_addr = 8'h0; pl_data = 8'h0;
    repeat (2) tick();
    n_checks++;
    if ({busy, done, err, mem_writeEnable} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, err, mem_writeEnable});
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    n_checks++;
    if (mem_wordaddr !== 32'h0 || mem_writeData !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_membus: got addr %h data %h expected 0/0", mem_wordaddr, mem_writeData);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word();
    int cyc; logic [31:0] rd; logic er;
    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, cyc, rd, er);
    n_checks++;
    if (cyc !== 4) begin
      n_fail++; $display("[TB] FAIL word_store_latency: got %0d expected 4", cyc);
    end
    n_checks++;
    if ({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL word_store_mem: got %h expected deadbeef",
                         {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]});
    end
    n_checks++;
    if (mem_wordaddr !== 32'h13) begin
      n_fail++; $display("[TB] FAIL idle_addr_hold: got %h expected 00000013", mem_wordaddr);
    end
    do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("[TB] FAIL word_load: got %h expected deadbeef", rd);
    end
    n_checks++;
    if (cyc !== 4) begin
      n_fail++; $display("[TB] FAIL word_load_latency: got %0d expected 4", cyc);
    end
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL done_pulse: got done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_byte_load();
    int cyc; logic [31:0] rd; logic er;
    preload(8'h20, 8'h80);
    preload(8'h21, 8'h7F);
    do_access(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || cyc !== 1) begin
      n_fail++; $display("[TB] FAIL byte_signed: got %h/%0d expected ffffff80/1", rd, cyc);
    end
    do_access(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'h00000080) begin
      n_fail++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", rd);
    end
    do_access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'h0000007F) begin
      n_fail++; $display("[TB] FAIL byte_signed_pos: got %h expected 0000007f", rd);
    end
  endtask

  task automatic test_half();
    int cyc; logic [31:0] rd; logic er;
    preload(8'h2F, 8'h55);
    preload(8'h30, 8'h55);
    preload(8'h31, 8'h55);
    preload(8'h32, 8'h55);
    do_access(1'b1, 2'b01, 1'b0, 32'h30, 32'h1234ABCD, cyc, rd, er);
    n_checks++;
    if ({mem[8'h2F], mem[8'h30], mem[8'h31], mem[8'h32]} !== 32'h55ABCD55 || cyc !== 2) begin
      n_fail++; $display("[TB] FAIL half_store: got %h/%0d expected 55abcd55/2",
                         {mem[8'h2F], mem[8'h30], mem[8'h31], mem[8'h32]}, cyc);
    end
    do_access(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'hFFFFABCD) begin
      n_fail++; $display("[TB] FAIL half_signed: got %h expected ffffabcd", rd);
    end
    do_access(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'h0000ABCD) begin
      n_fail++; $display("[TB] FAIL half_unsigned: got %h expected 0000abcd", rd);
    end
  endtask

  task automatic test_back_to_back();
    int writes; int done_at; int guard;
    logic [5:0] busy_seen;
    writes = 0; done_at = -1; busy_seen = '0;
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h50; req_wdata = 32'hCAFEF00D;
    req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k < 6) begin
        busy_seen[k] = busy;
        if (mem_writeEnable === 1'b1) writes++;
        if (done === 1'b1 && done_at < 0) done_at = k;
      end
      if (k == 6) begin
        n_checks++;
        if (busy !== 1'b1 || mem_writeEnable !== 1'b1) begin
          n_fail++; $display("[TB] FAIL reaccept: got busy %b we %b expected 1 1", busy, mem_writeEnable);
        end
      end
    end
    req = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    n_checks++;
    if (writes !== 4 || done_at !== 4) begin
      n_fail++; $display("[TB] FAIL held_req_single: got writes %0d done_at %0d expected 4 4", writes, done_at);
    end
    n_checks++;
    if (busy_seen !== 6'b011111) begin
      n_fail++; $display("[TB] FAIL held_req_busy: got %b expected 011111", busy_seen);
    end
    n_checks++;
    if ({mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]} !== 32'hCAFEF00D || guard >= 20) begin
      n_fail++; $display("[TB] FAIL held_req_mem: got %h expected cafef00d",
                         {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]});
    end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    saw_done = 1'b0;
    for (int a = 8'h40; a < 8'h44; a++) preload(8'(a), 8'h00);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_writeEnable !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_immediate: got we %b busy %b expected 0 0", mem_writeEnable, busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_no_done: got %b expected 0", saw_done);
    end
    n_checks++;
    if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'h11000000) begin
      n_fail++; $display("[TB] FAIL abort_mem: got %h expected 11000000",
                         {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
    end
  endtask

  task automatic test_misaligned();
    int cyc; logic [31:0] rd; logic er;
`ifdef MEM_ALIGN_CHECK_EN
    do_access(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, cyc, rd, er);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h41;
    req = 1'b1;
    tick();
    req = 1'b0;
    n_checks++;
    if ({done, err, mem_writeEnable, busy} !== 4'b1101) begin
      n_fail++; $display("[TB] FAIL misalign_word: got %b expected 1101", {done, err, mem_writeEnable, busy});
    end
    n_checks++;
    if (rdata !== 32'h00000080) begin
      n_fail++; $display("[TB] FAIL misalign_rdata: got %h expected 00000080", rdata);
    end
    tick();
    n_checks++;
    if ({done, err, busy} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL misalign_after: got %b expected 000", {done, err, busy});
    end
    preload(8'h31, 8'h99);
    do_access(1'b1, 2'b01, 1'b0, 32'h31, 32'h00000000, cyc, rd, er);
    n_checks++;
    if (cyc !== 0 || er !== 1'b1 || mem[8'h31] !== 8'h99) begin
      n_fail++; $display("[TB] FAIL misalign_half: got %0d/%b/%h expected 0/1/99", cyc, er, mem[8'h31]);
    end
    do_access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, cyc, rd, er);
    n_checks++;
    if (cyc !== 0 || er !== 1'b1 || rd !== 32'h00000080) begin
      n_fail++; $display("[TB] FAIL misalign_size11: got %0d/%b/%h expected 0/1/00000080", cyc, er, rd);
    end
`else
    preload(8'h41, 8'h01);
    preload(8'h42, 8'h02);
    preload(8'h43, 8'h03);
    preload(8'h44, 8'h04);
    do_access(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'h01020304 || cyc !== 4 || er !== 1'b0) begin
      n_fail++; $display("[TB] FAIL unaligned_word: got %h/%0d/%b expected 01020304/4/0", rd, cyc, er);
    end
    do_access(1'b0, 2'b11, 1'b1, 32'h41, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'h01020304 || cyc !== 4) begin
      n_fail++; $display("[TB] FAIL size11_as_word: got %h/%0d expected 01020304/4", rd, cyc);
    end
    preload(8'hFE, 8'hA1);
    preload(8'hFF, 8'hA2);
    preload(8'h00, 8'hA3);
    preload(8'h01, 8'hA4);
    do_access(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, cyc, rd, er);
    n_checks++;
    if (rd !== 32'hA1A2A3A4 || mem_wordaddr !== 32'h00000001) begin
      n_fail++; $display("[TB] FAIL addr_wrap: got %h addr %h expected a1a2a3a4 addr 00000001", rd, mem_wordaddr);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_word();
    test_byte_load();
    test_half();
    test_back_to_back();
    test_reset_abort();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
